// File: rtl/request_encoder_pkg.sv
// rtl/request_encoder_pkg.sv - shared defaults, state encoding and width helper for request_encoder
package request_encoder_pkg;

  localparam int N_DEFAULT = 4;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/request_encoder_prio_select.sv
// rtl/request_encoder_prio_select.sv - combinational first-set search from a start index, wrapping
module prio_select
  import request_encoder_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic [(1<<N)-1:0] pend,
  input  logic [N-1:0]      start,
  output logic              found,
  output logic [N-1:0]      idx
);

  localparam int W = 1 << N;

  logic [N-1:0] j;

  // Scan from farthest to nearest so the nearest set bit at or above start wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = '0;
    for (int k = W - 1; k >= 0; k--) begin
      j = start + N'(k);
      if (pend[j]) begin
        found = 1'b1;
        idx   = j;
      end
    end
  end

endmodule

// File: rtl/request_encoder.sv
// rtl/request_encoder.sv - multi-hot request vector to encoded address stream, valid/ready drained
// Optional ROUND_ROBIN_EN: rotating start pointer instead of lowest-index priority.
module request_encoder
  import request_encoder_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [(1<<N)-1:0]   req,
  output logic [N-1:0]        addr_out,
  output logic                valid,
  input  logic                ready,
  output logic [(1<<N)-1:0]   pend_vec,
  output logic                busy
);

  localparam int W = 1 << N;

  if (clog2(W) != N) begin : g_width_check
    $error("request_encoder: request width does not match address width");
  end

  state_t          state;
  logic            found;
  logic            load;
  logic [N-1:0]    sel_idx;
  logic [N-1:0]    start_idx;
  logic [W-1:0]    clr_mask;
  logic [W-1:0]    pend_next;

`ifdef ROUND_ROBIN_EN
  logic [N-1:0]    rr_ptr;

  always_ff @(posedge clk) begin
    if (rst)
      rr_ptr <= '0;
    else if (load)
      rr_ptr <= sel_idx + N'(1);
  end

  assign start_idx = rr_ptr;
`else
  assign start_idx = '0;
`endif

  prio_select #(.N(N)) u_prio_select (
    .pend  (pend_vec),
    .start (start_idx),
    .found (found),
    .idx   (sel_idx)
  );

  // Selection only looks at already-latched pending bits, never same-edge req.
  assign load = found && ((state == EMPTY) || ready);

  always_comb begin
    clr_mask = '0;
    if (load) clr_mask[sel_idx] = 1'b1;
    pend_next = (pend_vec & ~clr_mask) | (en ? req : '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= EMPTY;
      addr_out <= '0;
      pend_vec <= '0;
    end else begin
      pend_vec <= pend_next;
      case (state)
        EMPTY: begin
          if (found) begin
            addr_out <= sel_idx;
            state    <= FULL;
          end
        end
        FULL: begin
          if (ready) begin
            if (found) addr_out <= sel_idx;
            else       state    <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign valid = (state == FULL);
  assign busy  = valid || (pend_vec != '0);

endmodule

// File: tb/tb_request_encoder.sv
// tb/tb_request_encoder.sv - table-driven and sequence checks for request_encoder
module tb_request_encoder;

  localparam int N = 4;
  localparam int W = 1 << N;

  logic         clk;
  logic         rst;
  logic         en;
  logic [W-1:0] req;
  logic [N-1:0] addr_out;
  logic         valid;
  logic         ready;
  logic [W-1:0] pend_vec;
  logic         busy;

  int errors = 0;
  int checks = 0;

  request_encoder #(.N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .req      (req),
    .addr_out (addr_out),
    .valid    (valid),
    .ready    (ready),
    .pend_vec (pend_vec),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic         en;
    logic [15:0]  req;
    logic         ready;
    logic         exp_valid;
    logic [3:0]   exp_addr;
    logic [15:0]  exp_pend;
    logic         exp_busy;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic [W-1:0] q, input logic rdy);
    rst   = r;
    en    = e;
    req   = q;
    ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic r, input logic e, input logic [15:0] q, input logic rdy,
                     input logic v, input logic [3:0] a, input logic [15:0] p, input logic b);
    vec_t t;
    t.rst = r; t.en = e; t.req = q; t.ready = rdy;
    t.exp_valid = v; t.exp_addr = a; t.exp_pend = p; t.exp_busy = b;
    vecs.push_back(t);
  endtask

  // Accept everything until idle, recording each accepted address.
  task automatic drain(output int n, output logic [N-1:0] got[$]);
    int budget;
    n = 0;
    got.delete();
    budget = 0;
    while ((valid || busy) && budget < 40) begin
      if (valid) begin
        got.push_back(addr_out);
        n++;
      end
      step(1'b0, 1'b0, '0, 1'b1);
      budget++;
    end
    check("drain_terminates", {31'd0, busy}, 32'd0);
  endtask

  logic [N-1:0] got_q[$];
  logic [N-1:0] exp_rr[4];
  int           n_xfer;
  int           n3;

  initial begin
    rst = 1'b1; en = 1'b1; req = '1; ready = 1'b0;

    // reset with all requests asserted
    add(1, 1, 16'hFFFF, 0,  0, 4'd0,  16'h0000, 0);
    add(1, 1, 16'hFFFF, 0,  0, 4'd0,  16'h0000, 0);
    // single pulse request for address 5
    add(0, 1, 16'h0020, 1,  0, 4'd0,  16'h0020, 1);
    add(0, 1, 16'h0000, 1,  1, 4'd5,  16'h0000, 1);
    add(0, 1, 16'h0000, 1,  0, 4'd5,  16'h0000, 0);
    add(0, 0, 16'h0000, 1,  0, 4'd5,  16'h0000, 0);
    add(1, 0, 16'h0000, 0,  0, 4'd0,  16'h0000, 0);
    // backpressure then drain in priority order
    add(0, 1, 16'h8101, 0,  0, 4'd0,  16'h8101, 1);
    add(0, 1, 16'h0000, 0,  1, 4'd0,  16'h8100, 1);
    add(0, 1, 16'h0000, 0,  1, 4'd0,  16'h8100, 1);
    add(0, 1, 16'h0000, 0,  1, 4'd0,  16'h8100, 1);
    add(0, 1, 16'h0000, 0,  1, 4'd0,  16'h8100, 1);
    add(0, 1, 16'h0000, 0,  1, 4'd0,  16'h8100, 1);
    add(0, 1, 16'h0000, 1,  1, 4'd8,  16'h8000, 1);
    add(0, 1, 16'h0000, 1,  1, 4'd15, 16'h0000, 1);
    add(0, 1, 16'h0000, 1,  0, 4'd15, 16'h0000, 0);
    // reset overrides a pending transfer and new requests
    add(0, 1, 16'h0004, 0,  0, 4'd15, 16'h0004, 1);
    add(0, 1, 16'h0000, 0,  1, 4'd2,  16'h0000, 1);
    add(1, 1, 16'hFFFF, 1,  0, 4'd0,  16'h0000, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].en, vecs[i].req, vecs[i].ready);
      check($sformatf("vec%0d_valid", i), {31'd0, valid}, {31'd0, vecs[i].exp_valid});
      check($sformatf("vec%0d_addr", i),  {28'd0, addr_out}, {28'd0, vecs[i].exp_addr});
      check($sformatf("vec%0d_pend", i),  {16'd0, pend_vec}, {16'd0, vecs[i].exp_pend});
      check($sformatf("vec%0d_busy", i),  {31'd0, busy}, {31'd0, vecs[i].exp_busy});
    end

    // set wins: bit 3 re-requested on the edge that loads it
    step(1, 0, '0, 0);
    step(0, 1, 16'h0008, 0);
    step(0, 1, 16'h0008, 0);
    check("setwin_valid", {31'd0, valid}, 32'd1);
    check("setwin_addr", {28'd0, addr_out}, 32'd3);
    check("setwin_pend", {16'd0, pend_vec}, 32'h0008);
    drain(n_xfer, got_q);
    n3 = 0;
    foreach (got_q[i]) if (got_q[i] == 4'd3) n3++;
    check("setwin_count", n_xfer, 32'd2);
    check("setwin_count3", n3, 32'd2);

    // held request pair: fixed repeats 2, round-robin alternates
`ifdef ROUND_ROBIN_EN
    exp_rr = '{4'd2, 4'd9, 4'd2, 4'd9};
`else
    exp_rr = '{4'd2, 4'd2, 4'd2, 4'd2};
`endif
    step(1, 0, '0, 0);
    step(0, 1, 16'h0204, 1);
    check("hold_first_valid", {31'd0, valid}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 16'h0204, 1);
      check($sformatf("hold_valid%0d", i), {31'd0, valid}, 32'd1);
      check($sformatf("hold_grant%0d", i), {28'd0, addr_out}, {28'd0, exp_rr[i]});
    end

    // en gating: nothing captured with en low, then one capture of all ones
    step(1, 0, '0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 16'hFFFF, 1);
    check("engate_valid", {31'd0, valid}, 32'd0);
    check("engate_pend", {16'd0, pend_vec}, 32'd0);
    check("engate_busy", {31'd0, busy}, 32'd0);
    step(0, 1, 16'hFFFF, 1);
    check("engate_capture", {16'd0, pend_vec}, 32'hFFFF);
    drain(n_xfer, got_q);
    check("allones_count", n_xfer, 32'd16);
    for (int i = 0; i < 16; i++) begin
      if (i < got_q.size())
        check($sformatf("allones_order%0d", i), {28'd0, got_q[i]}, i);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/request_encoder.md
Name: request_encoder

Overview:
- Inverse of the word-line decoder: collects a 2**N-bit one-hot/multi-hot request vector and emits one N-bit encoded address per transfer over a valid/ready handshake.
- Sits between word-line/request sources (interrupt lines, bank requests) and address-consuming logic such as the register file or memory address mux.
- Requests are latched into a pending register and drained one per accepted transfer. Selection is lowest-index fixed priority, or round-robin when the optional feature is compiled in.

Parameters:
- N, 4, encoded address width; request vector width is 2**N.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  request capture enable; when 0, req is ignored.
- req  input  2**N  request lines, bit i requests address i; level or pulse, sampled each edge.
- addr_out  output  N  encoded address of the current transfer.
- valid  output  1  addr_out holds a transfer.
- ready  input  1  consumer accepts when valid && ready at a rising edge.
- pend_vec  output  2**N  pending requests not yet loaded into the output stage.
- busy  output  1  valid || (pend_vec != 0).

Behaviour:
- Reset (rst=1 at an edge): pend_vec=0, addr_out=0, valid=0, busy=0, RR pointer=0. Reset overrides all simultaneous events.
- Capture: at each edge, next pend_vec = (pend_vec & ~clr_mask) | (en ? req : 0).
  - clr_mask is the one-hot bit of the index loaded this edge, else 0.
  - Set wins: a bit that is simultaneously cleared and re-requested stays pending.
- FSM, two states, encoded by valid:
  - EMPTY (valid=0): if pend_vec != 0, select an index, load addr_out, set valid, clear that pend bit. Go to FULL.
  - FULL (valid=1): addr_out and valid hold stable while ready=0.
    - On valid && ready with pend_vec (excluding same-edge req) != 0: load the next selection in the same edge and stay FULL (back-to-back, one transfer per cycle).
    - On valid && ready with pend_vec == 0: valid goes to 0, go to EMPTY. addr_out retains its last value.
- Latency:
  - req sampled at edge k gives pend bit set after k.
  - Earliest valid=1 with that address is after edge k+1, i.e. 2 cycles.
  - There is no combinational req-to-addr_out path.
- Fixed priority (macro absent): the lowest set index of pend_vec wins.
- Duplicate requests: re-asserting an already-pending bit is absorbed (no count). One transfer is produced per pending bit.
- A request for the index currently held in addr_out while FULL is re-pended and transferred again later.
- All-ones req at N=4 drains in 16 accepted transfers, indices 0..15 in order (fixed priority).
- Deasserting en mid-operation stops new captures only. Pending and output drain normally.
- ready while valid=0 has no effect.

Optional Feature:
- ROUND_ROBIN_EN defined:
  - Adds an N-bit pointer, reset 0.
  - Selection is the first set pend bit searching upward from the pointer, wrapping 2**N-1 -> 0.
  - On each load, pointer = loaded index + 1 mod 2**N.
- ROUND_ROBIN_EN undefined: fixed lowest-index priority, no pointer register.
- Handshake, latency and reset behaviour are identical in both builds.

Decomposition:
- Shared package/include holds:
  - Default N.
  - State encodings EMPTY=1'b0, FULL=1'b1.
  - Function clog2 for width checks.
- One sub-module, prio_select:
  - Combinational; inputs pend vector and start index (tied 0 without ROUND_ROBIN_EN).
  - Outputs found flag and N-bit index.
  - Mirror of the decoder, so the bench can check the round trip addr -> decoder -> encoder.

Test Plan:
- Reset: rst=1 for 2 cycles with req=16'hFFFF, en=1 -> valid=0, pend_vec=0, addr_out=0, busy=0 throughout.
- Single request: req=16'h0020 for one cycle, ready=1 -> valid=1 with addr_out=5 two cycles later for exactly one cycle, then busy=0.
- Backpressure/priority (fixed): req=16'h8101 in one cycle, ready=0 for 5 cycles, then 1.
  - addr_out=0 holds stable while ready=0.
  - Then 8, then 15 on consecutive cycles; pend_vec goes 16'h8100 -> 16'h8000 -> 0.
- Set-wins collision: while addr 3 is being loaded, req bit 3 is asserted the same edge -> addr 3 is transferred twice in total.
- Round-robin (ROUND_ROBIN_EN):
  - Last grant was 9; req=16'h0204 held high, ready=1 -> grants alternate 2, 9, 2, 9.
  - Without the macro, req=16'h0204 held high -> grants are all 2.
- en gating: en=0, req=16'hFFFF -> no valid. en=1 for one cycle -> exactly 16 transfers.
